// File: rtl/alu_defs.sv
// Shared ALU definitions: operand width and ALUOp encodings.
// Imported by the ALU and by the arbiter that shares it.
package alu_defs;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_OR  = 2'b10,
    ALU_NOP = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Shared 32-bit ALU: add/sub/or, NOP yields 0.
// Ports: a, b, op -> result, zero (a==b), less (signed a<b).
module alu_arbiter_alu
  import alu_defs::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              less
);

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_OR:  result = a | b;
      ALU_NOP: result = '0;
      default: result = '0;
    endcase
  end

  // Flags compare the operands, independent of op
  assign zero = (a == b);
  assign less = ($signed(a) < $signed(b));

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for the shared ALU with
// per-requester registered response slots and a conflict counter.
// Ports: req_* (valid/ready/a/b/op/tag), rsp_* (valid/ready/result/
// zero/less/tag), conflict_cnt; clk, reset (sync, active-low).
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 4,
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [2*DATA_W-1:0]   req_a,
  input  logic [2*DATA_W-1:0]   req_b,
  input  logic [3:0]            req_op,
  input  logic [2*TAG_W-1:0]    req_tag,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [2*DATA_W-1:0]   rsp_result,
  output logic [1:0]            rsp_zero,
  output logic [1:0]            rsp_less,
  output logic [2*TAG_W-1:0]    rsp_tag,
  output logic [CNT_W-1:0]      conflict_cnt
);

  import alu_defs::*;

  logic [1:0] elig;
  logic [1:0] grant;
  logic       sel;

  logic prio_q, prio_d;
  logic [1:0] vld_q, vld_d;
  logic [1:0][DATA_W-1:0] res_q, res_d;
  logic [1:0] zero_q, zero_d;
  logic [1:0] less_q, less_d;
  logic [1:0][TAG_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [DATA_W-1:0] alu_a, alu_b, alu_res;
  logic [1:0]        op_sel;
  logic              alu_zero, alu_less;

  // A slot that is draining this cycle can take a new result
  assign elig = req_valid & (~vld_q | rsp_ready);

  always_comb begin
    grant = 2'b00;
    if (reset) begin
      unique case (elig)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;

  // No grant falls back to requester 0; result unused
  assign sel    = grant[1];
  assign alu_a  = sel ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
  assign alu_b  = sel ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
  assign op_sel = sel ? req_op[3:2] : req_op[1:0];

  alu_arbiter_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op_e'(op_sel)),
    .result (alu_res),
    .zero   (alu_zero),
    .less   (alu_less)
  );

  always_comb begin
    prio_d = prio_q;
    if (grant[0])
      prio_d = 1'b1;
    else if (grant[1])
      prio_d = 1'b0;
  end

  always_comb begin
    vld_d  = vld_q;
    res_d  = res_q;
    zero_d = zero_q;
    less_d = less_q;
    tag_d  = tag_q;
    for (int i = 0; i < 2; i++) begin
      if (grant[i]) begin
        vld_d[i]  = 1'b1;
        res_d[i]  = alu_res;
        zero_d[i] = alu_zero;
        less_d[i] = alu_less;
        tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
      end else if (vld_q[i] && rsp_ready[i]) begin
        vld_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (elig == 2'b11 && cnt_q != '1)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q <= RR_INIT;
      vld_q  <= '0;
      res_q  <= '0;
      zero_q <= '0;
      less_q <= '0;
      tag_q  <= '0;
      cnt_q  <= '0;
    end else begin
      prio_q <= prio_d;
      vld_q  <= vld_d;
      res_q  <= res_d;
      zero_q <= zero_d;
      less_q <= less_d;
      tag_q  <= tag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rsp_valid    = vld_q;
  assign rsp_result   = res_q;
  assign rsp_zero     = zero_q;
  assign rsp_less     = less_q;
  assign rsp_tag      = tag_q;
  assign conflict_cnt = cnt_q;

endmodule
